// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
// Defaults describe the standard 8-word configuration.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    // The pointer carries one extra wrap bit above the address bits.
    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable.
// The top bit is the wrap bit; the low bits form the memory address.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int W = FIFO_ADDR_WIDTH + 1
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    localparam logic [W-1:0] INC_C = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_ptr;

    // Pointer register: advance by one on each accepted access, wrapping naturally.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr <= {W{1'b0}};
        end else if (i_inc) begin
            r_ptr <= r_ptr + INC_C;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving a dual-port memory with registered read.
// Optional sticky overflow/underflow flag enabled by macro FIFO_ERROR_FLAG_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  data_valid,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic                w_push_ok;
    logic                w_pop_ok;
    logic [ADDR_WIDTH:0] w_wr_ptr;
    logic [ADDR_WIDTH:0] w_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_data_valid;

    // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle.
    assign w_push_ok = push & (~full | pop) & reset_L;
    assign w_pop_ok  = pop & ~empty & reset_L;

    assign write_enable = w_push_ok;
    assign read_enable  = w_pop_ok;

    fifo_ptr #(.W(ADDR_WIDTH + 1)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .i_inc   (w_push_ok),
        .o_ptr   (w_wr_ptr)
    );

    fifo_ptr #(.W(ADDR_WIDTH + 1)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .i_inc   (w_pop_ok),
        .o_ptr   (w_rd_ptr)
    );

    assign write_addr = w_wr_ptr[ADDR_WIDTH-1:0];
    assign read_addr  = w_rd_ptr[ADDR_WIDTH-1:0];

    // Occupancy register: net change of accepted push minus accepted pop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read-valid strobe tracks the memory's one-cycle registered read.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_pop_ok;
        end
    end

    assign count        = r_count;
    assign data_valid   = r_data_valid;
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == {(ADDR_WIDTH + 1){1'b0}});
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);

`ifdef FIFO_ERROR_FLAG_EN
    logic r_error;

    // Sticky error: set by any rejected request, cleared only by reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_error <= 1'b0;
        end else if ((push & full & ~pop) | (pop & empty)) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: directed cycles queue hand-derived expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fifo_ctrl;
    import fifo_pkg::*;

`ifdef FIFO_ERROR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit     we;
        bit     re;
        int     wa;
        int     ra;
        count_t cnt;
        bit     dv;
        bit     err;
    } exp_t;

    logic                       clk;
    logic                       reset_L;
    logic                       push;
    logic                       pop;
    logic                       write_enable;
    logic                       read_enable;
    logic [FIFO_ADDR_WIDTH-1:0] write_addr;
    logic [FIFO_ADDR_WIDTH-1:0] read_addr;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    count_t                     count;
    logic                       data_valid;
    logic                       error;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   e_err   = 1'b0;

    fifo_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .data_valid   (data_valid),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("write_enable", int'(write_enable), int'(e.we));
            chk("read_enable",  int'(read_enable),  int'(e.re));
            chk("write_addr",   int'(write_addr),   e.wa);
            chk("read_addr",    int'(read_addr),    e.ra);
            chk("count",        int'(count),        int'(e.cnt));
            chk("full",         int'(full),         int'(e.cnt == 4'd8));
            chk("empty",        int'(empty),        int'(e.cnt == 4'd0));
            chk("almost_full",  int'(almost_full),  int'(e.cnt >= 4'd6));
            chk("almost_empty", int'(almost_empty), int'(e.cnt <= 4'd1));
            chk("data_valid",   int'(data_valid),   int'(e.dv));
            chk("error",        int'(error),        int'(e.err));
        end
    end

    // One cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic cyc(input bit rn, input bit pu, input bit po,
                       input bit we, input bit re, input int wa, input int ra,
                       input int cnt, input bit dv, input bit rej);
        exp_t e;
        @(posedge clk);
        #1;
        reset_L = rn;
        push    = pu;
        pop     = po;
        if (!rn) e_err = 1'b0;
        e.we  = we;
        e.re  = re;
        e.wa  = wa;
        e.ra  = ra;
        e.cnt = count_t'(cnt);
        e.dv  = dv;
        e.err = e_err;
        q.push_back(e);
        if (rej) e_err = ERR_EN;
    endtask

    initial begin
        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;

        // Reset and idle
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Fill, then a rejected push while full
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, i, 0, i, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8, 1'b0, 1'b1);

        // Drain, then a rejected pop while empty
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, i, 8 - i, (i > 0), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Wrap: push 5, pop 5, push 5
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, i, 0, i, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5, i, 5 - i, (i > 0), 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (5 + i) % 8, 5, i, (i == 0), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 5, 5, 1'b0, 1'b0);

        // Top up to full, then simultaneous push+pop while full
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2 + i, 5, 5 + i, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 5, 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6, (6 + i) % 8, 8 - i, 1'b1, 1'b0);

        // Simultaneous push+pop while empty: only the write goes through
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6, 6, 0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7, 6, 1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7, 7, 0, 1'b1, 1'b1);

        // Valid traffic keeps the sticky flag; reset mid-burst clears everything
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7, 7, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 7, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 1'b0, 1'b0);

        // Let the monitor drain the scoreboard, bounded
        for (int k = 0; k < 5 && q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer/flag controller that drives the FIFO's dual-port memory.
- Accepts push/pop requests from the producer and consumer.
- Generates write/read enables and addresses for the memory.
- Tracks occupancy; produces full/empty, almost-full/almost-empty and a read-data-valid strobe matching the memory's 1-cycle registered read.
- Sits between the FIFO's external handshake and the memory instance inside the FIFO wrapper.

Parameters:
ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH words; the paired memory must hold at least DEPTH words.
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
clk  input  1  single clock, all state on rising edge.
reset_L  input  1  asynchronous, active-low reset.
push  input  1  producer requests a write this cycle.
pop  input  1  consumer requests a read this cycle.
write_enable  output  1  to memory; high when push accepted (combinational).
read_enable  output  1  to memory; high when pop accepted (combinational).
write_addr  output  ADDR_WIDTH  to memory; low bits of write pointer (registered).
read_addr  output  ADDR_WIDTH  to memory; low bits of read pointer (registered).
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  ADDR_WIDTH+1  occupancy 0..DEPTH (registered).
data_valid  output  1  memory output word is new this cycle (read_enable delayed 1 cycle).
error  output  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset (reset_L low, asynchronous):
  - wr_ptr = rd_ptr = 0; count = 0.
  - empty = 1, almost_empty = 1 (AE_THRESH >= 0), full = 0, almost_full = 0.
  - data_valid = 0, error = 0.
  - Enables are forced 0 while reset_L is low.
- Pointers are ADDR_WIDTH+1 bits wide; the extra MSB is the wrap bit. Addresses are the low ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
- Accept rules:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- Simultaneous push and pop:
  - When full: both accepted. The write and read target the same address; the read returns the old word because the memory read is registered. Count stays DEPTH.
  - When empty: only push accepted. Count becomes 1; data_valid stays 0.
  - Otherwise: both accepted; count unchanged.
- write_enable = push_ok; read_enable = pop_ok.
- On each clk edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - count += push_ok - pop_ok.
  - data_valid <= pop_ok.
- Flags are decoded combinationally from the registered count. They are valid the cycle after the causing request; no lookahead.
- Latency:
  - Pop request at edge N -> data on memory output with data_valid = 1 during cycle N+1.
  - Pushed word is poppable from the next cycle onward.
- Rejected requests (push while full without pop, or pop while empty) change no state and generate no memory access.
- Reset mid-operation discards contents logically; memory contents are not cleared.

Optional Feature:
Macro FIFO_ERROR_FLAG_EN.
- Defined: error is set on a rejected push (push & full & ~pop) or a rejected pop (pop & empty). It stays set until reset_L is asserted.
- Undefined: no error logic is generated; error is tied to 0.
- All other behaviour is identical with or without the macro.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDR_WIDTH and DEPTH constants;
  - pointer type (ADDR_WIDTH+1 bits);
  - count type.
- One natural sub-module: fifo_ptr, a wrapping pointer register with increment-enable. It is instantiated twice (write side, read side).
- Flag decode and count logic stay in fifo_ctrl.

Test Plan:
1. Reset then idle -> empty=1, almost_empty=1, full=0, count=0, write_addr=read_addr=0, data_valid=0.
2. 8 consecutive pushes (ADDR_WIDTH=3):
   - write_addr steps 0..7; count 1..8.
   - almost_full rises after the 6th push; full=1 after the 8th.
   - A 9th push gives write_enable=0 and count stays 8.
3. From full, 8 pops:
   - read_addr 0..7; data_valid high the cycle after each pop.
   - empty=1 after the last pop.
   - A 9th pop gives read_enable=0.
4. Wrap: push 5, pop 5, push 5 -> write_addr sequence 5,6,7,0,1; count=5; pointer MSB toggled, no false full.
5. Simultaneous push+pop:
   - When full: both enables 1, same address, count stays 8, old word read.
   - When empty: only write_enable=1, count=1, data_valid=0.
6. With FIFO_ERROR_FLAG_EN: pop on empty -> error=1 and remains 1 through later valid traffic until reset_L=0 mid-burst, which clears all state asynchronously.
